// File: rtl/interleave_addr_seq.sv
// QPP interleaver address sequencer: emits (i, pi(i)) pairs with a valid/ready handshake.
// Optional abort input enabled by defining ILV_SEQ_ABORT_EN.
module interleave_addr_seq #(
    parameter int F1 = 31,
    parameter int F2 = 64,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len_m1,
    input  logic          ready,
`ifdef ILV_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          valid,
    output logic [AW-1:0] addr_nat,
    output logic [AW-1:0] addr_int,
    output logic          last,
    output logic          busy,
    output logic          done
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | presenting beats, advancing on valid && ready
    // S_DONE | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW-1:0] C_G0 = AW'(F1 + F2);
    localparam logic [AW-1:0] C_DG = AW'(2 * F2);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_pi;
    logic [AW-1:0] r_g;
    logic [AW-1:0] r_len;
    logic          w_run;
    logic          w_abort;
    logic          w_accept;
    logic          w_is_last;

`ifdef ILV_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run     = (r_state == S_RUN);
    assign w_is_last = (r_i == r_len);
    // abort takes priority, so a beat presented alongside abort is dropped
    assign w_accept  = w_run && ready && !w_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN: begin
                if (w_abort)
                    w_next = S_IDLE;
                else if (w_accept && w_is_last)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // pi(i+1) - pi(i) = F1 + F2*(2i+1), itself stepping by 2*F2 per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i   <= '0;
            r_pi  <= '0;
            r_g   <= '0;
            r_len <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_i   <= '0;
            r_pi  <= '0;
            r_g   <= C_G0;
            r_len <= len_m1;
        end else if (w_accept) begin
            r_i   <= r_i + 1'b1;
            r_pi  <= r_pi + r_g;
            r_g   <= r_g + C_DG;
        end
    end

    assign valid    = w_run;
    assign busy     = w_run;
    assign done     = (r_state == S_DONE);
    assign addr_nat = w_run ? r_i  : '0;
    assign addr_int = w_run ? r_pi : '0;
    assign last     = w_run && w_is_last;

endmodule

// File: tb/tb_interleave_addr_seq.sv
// Randomized self-checking bench for interleave_addr_seq against a closed-form QPP model.
// Abort scenario is exercised when ILV_SEQ_ABORT_EN is defined.
module tb_interleave_addr_seq;

    localparam int F1 = 31;
    localparam int F2 = 64;
    localparam int AW = 12;
    localparam int K  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len_m1 = '0;
    logic          ready = 1'b0;
    logic          abort = 1'b0;
    logic          valid;
    logic [AW-1:0] addr_nat;
    logic [AW-1:0] addr_int;
    logic          last;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    bit seen [K];

    interleave_addr_seq #(.F1(F1), .F2(F2), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_m1   (len_m1),
        .ready    (ready),
`ifdef ILV_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .valid    (valid),
        .addr_nat (addr_nat),
        .addr_int (addr_int),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pi(input int i);
        longint v;
        v = longint'(F1) * i + longint'(F2) * i * i;
        return int'(v % K);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input int exp_done);
        check_val({tag, ".valid"}, int'(valid), 0);
        check_val({tag, ".busy"}, int'(busy), 0);
        check_val({tag, ".done"}, int'(done), exp_done);
        check_val({tag, ".nat"}, int'(addr_nat), 0);
        check_val({tag, ".int"}, int'(addr_int), 0);
        check_val({tag, ".last"}, int'(last), 0);
    endtask

    task automatic check_beat(input int idx, input int len);
        check_val("beat.valid", int'(valid), 1);
        check_val("beat.busy", int'(busy), 1);
        check_val("beat.done", int'(done), 0);
        check_val("beat.nat", int'(addr_nat), idx);
        check_val("beat.int", int'(addr_int), ref_pi(idx));
        check_val("beat.last", int'(last), (idx == len) ? 1 : 0);
    endtask

    // Runs one block from IDLE; stall_pct gives random ready-low probability,
    // stall_at/stall_n force a ready-low run at one index, noise toggles start/len_m1.
    task automatic run_block(input int len, input int stall_pct, input int stall_at,
                             input int stall_n, input bit noise);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        int uniq = 0;
        for (int k = 0; k < K; k++) seen[k] = 1'b0;
        start  = 1'b1;
        len_m1 = AW'(len);
        ready  = 1'b1;
        step();
        start = 1'b0;
        while (idx <= len && cyc < 4 * K + 64) begin
            check_beat(idx, len);
            seen[addr_int] = 1'b1;
            if (idx == stall_at && stalled < stall_n) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = ($urandom_range(0, 99) >= stall_pct);
            end
            if (noise) begin
                start  = $urandom_range(0, 3) == 0;
                len_m1 = AW'($urandom);
            end
            step();
            if (ready) idx++;
            cyc++;
        end
        check_val("block.budget", (idx > len) ? 1 : 0, 1);
        if (len == K - 1) begin
            for (int k = 0; k < K; k++) uniq += int'(seen[k]);
            check_val("perm.unique", uniq, K);
        end
        start = noise ? 1'b1 : 1'b0;
        ready = 1'b1;
        check_quiet("done_cyc", 1);
        step();
        start = 1'b0;
        check_quiet("post_done", 0);
    endtask

    initial begin
        repeat (2) step();
        check_quiet("reset", 0);
        rst = 1'b0;

        // 5-beat block at full throughput; first start on first edge after reset
        run_block(4, 0, -1, 0, 1'b0);
        // full-size block: every index visited, last beat (4095,33)
        run_block(K - 1, 0, -1, 0, 1'b0);
        check_val("pi_final", ref_pi(K - 1), 33);
        // hold (2,318) for 4 cycles with three ready-low cycles
        run_block(4, 0, 2, 3, 1'b0);
        // single-beat block
        run_block(0, 0, -1, 0, 1'b1);

        // asynchronous reset between edges at beat 3
        start  = 1'b1;
        len_m1 = AW'(4);
        ready  = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check_beat(b, 4);
            step();
        end
        check_beat(3, 4);
        #2 rst = 1'b1;
        #1 check_quiet("async_rst", 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_block(4, 0, -1, 0, 1'b0);

`ifdef ILV_SEQ_ABORT_EN
        start  = 1'b1;
        len_m1 = AW'(4);
        ready  = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            check_beat(b, 4);
            step();
        end
        check_beat(2, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_quiet("abort", 0);
        step();
        check_quiet("abort_idle", 0);
        run_block(4, 0, -1, 0, 1'b0);
`endif

        for (int n = 0; n < 30; n++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 300))
                                              : int'($urandom_range(0, 20));
            run_block(len, int'($urandom_range(0, 60)), -1, 0, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                step();
                check_quiet("idle_gap", 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interleave_addr_seq.md
INTERLEAVE_ADDR_SEQ -- requirements
Module: interleave_addr_seq

Interface
REQ-001 Parameter F1, default 31, QPP linear coefficient.
REQ-002 Parameter F2, default 64, QPP quadratic coefficient.
REQ-003 Parameter AW, default 12, address width; interleaver size K = 2^AW (4096).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a block.
REQ-007 len_m1  input  AW  block length minus one, sampled only on accepted start.
REQ-008 ready  input  1  downstream accepts current address pair.
REQ-009 valid  output  1  addr_nat/addr_int/last hold a valid beat.
REQ-010 addr_nat  output  AW  natural-order index i.
REQ-011 addr_int  output  AW  interleaved address pi(i) = (F1*i + F2*i*i) mod K.
REQ-012 last  output  1  high with the beat where i == latched len_m1.
REQ-013 busy  output  1  high in RUN state.
REQ-014 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-015 States: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 -> RUN next edge; latch len_m1; i=0, pi=0, g=(F1+F2) mod K.
REQ-017 start is ignored in RUN and DONE; no queuing.
REQ-018 First valid beat appears the cycle after accepted start (latency 1); addr_nat=0, addr_int=0.
REQ-019 Beat accepted when valid && ready; on acceptance: i<=i+1, pi<=(pi+g) mod K, g<=(g+2*F2) mod K.
REQ-020 No multiplier in the datapath; pi generated only by the REQ-019 recurrence; all sums wrap at AW bits.
REQ-021 valid && !ready: addr_nat, addr_int, last, all internal state held unchanged.
REQ-022 valid == busy (high throughout RUN, including stalls); one beat per cycle with ready held high.
REQ-023 Accepted beat with last=1 -> DONE; valid, busy low in DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 len_m1=0: single beat (0,0) with last=1.
REQ-026 len_m1=K-1: K beats; addr_nat wraps nowhere; final beat i=K-1.
REQ-027 Outputs addr_nat/addr_int/last read 0 whenever valid=0.

Reset
REQ-028 rst=1 forces IDLE immediately, independent of clk, including mid-block.
REQ-029 During and after reset: valid=0, busy=0, done=0, last=0, addr_nat=0, addr_int=0; internal i, pi, g, latched length = 0.
REQ-030 First start is accepted on the first rising edge with rst=0.

Configuration
REQ-031 Macro ILV_SEQ_ABORT_EN: when defined, adds input abort (1 bit, after ready in port list).
REQ-032 With ILV_SEQ_ABORT_EN: abort=1 in RUN -> IDLE next edge, no done pulse, current beat dropped even if ready=1; abort ignored in IDLE/DONE.
REQ-033 Without ILV_SEQ_ABORT_EN: no abort port; blocks run to completion or reset only.

Verification
REQ-034 Reset, start with len_m1=4, ready=1 -> beats (0,0),(1,95),(2,318),(3,669),(4,1148 last=1), done pulse one cycle after beat 4.
REQ-035 len_m1=4095, ready=1 -> 4096 beats matching (31i+64i^2) mod 4096, final beat (4095,33) last=1; addr_int set is a permutation of 0..4095.
REQ-036 len_m1=4, ready low 3 cycles at beat 2 -> (2,318) held stable 4 cycles, sequence then continues unchanged.
REQ-037 start pulsed during RUN and in DONE cycle -> ignored; len_m1 changed mid-block has no effect.
REQ-038 rst asserted between clock edges at beat 3 -> valid/busy drop asynchronously; new start yields (0,0) again.
REQ-039 ILV_SEQ_ABORT_EN defined, abort at beat 2 with ready=1 -> IDLE next cycle, no done; restart begins at (0,0).
